// File: rtl/vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : vram_arbiter                                             |
// | Description : Single-port video-RAM arbiter. Video fetch has priority, |
// |               a starvation guard forces processor access, and returned |
// |               data is routed back to its requester by a tag pipeline.  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module vram_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [31:0]       video_address,
  output logic [DATA_W-1:0] video_data,
  output logic              video_valid,
  output logic              video_miss,
  output logic [15:0]       miss_cnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Return tags. Video and processor tags travel in separate lanes so a
  // forced processor read and the video slot it dropped can return together.
  localparam logic [2:0] TAG_NONE       = 3'd0;
  localparam logic [2:0] TAG_VID        = 3'd1;
  localparam logic [2:0] TAG_VID_DROP   = 3'd2;
  localparam logic [2:0] TAG_CPU_RD     = 3'd3;
  localparam logic [2:0] TAG_CPU_RD_OOR = 3'd4;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       cpu_win;
  logic       vid_win;
  logic       cpu_oor;
  logic [2:0] vid_tag_next;
  logic [2:0] cpu_tag_next;
  logic [2:0] vid_tag1;
  logic [2:0] cpu_tag1;
  logic [2:0] vid_tag2;
  logic [2:0] cpu_tag2;

  // Upper processor address bits decide range; upper video bits are ignored.
  generate
    if (ADDR_W < 32) begin : g_oor_chk
      logic unused_video_hi;
      assign cpu_oor         = |cpu_addr[31:ADDR_W];
      assign unused_video_hi = |video_address[31:ADDR_W];
    end else begin : g_oor_none
      assign cpu_oor = 1'b0;
    end
  endgenerate

  // Arbitration: video first unless the processor has waited STARVE_MAX cycles.
  always_comb begin
    cpu_win      = cpu_req && (!pix_en || (starve_cnt >= STARVE_LIM));
    vid_win      = pix_en && !cpu_win;
    vid_tag_next = TAG_NONE;
    cpu_tag_next = TAG_NONE;
    if (vid_win) begin
      vid_tag_next = TAG_VID;
    end else if (pix_en) begin
      vid_tag_next = TAG_VID_DROP;
    end
    if (cpu_win && !cpu_we) begin
      cpu_tag_next = cpu_oor ? TAG_CPU_RD_OOR : TAG_CPU_RD;
    end
  end

  assign cpu_gnt = cpu_win;

  // Count consecutive denied processor cycles; any grant or idle clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (cpu_req && !cpu_gnt) begin
      starve_cnt <= starve_cnt + 4'd1;
    end else begin
      starve_cnt <= 4'd0;
    end
  end

  // Stage 1: register the winner's RAM command and its return tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      vid_tag1  <= TAG_NONE;
      cpu_tag1  <= TAG_NONE;
    end else begin
      vid_tag1 <= vid_tag_next;
      cpu_tag1 <= cpu_tag_next;
      mem_we   <= 1'b0;
      if (cpu_win) begin
        mem_addr  <= cpu_addr[ADDR_W-1:0];
        mem_we    <= cpu_we && !cpu_oor;
        mem_wdata <= cpu_wdata;
      end else if (vid_win) begin
        mem_addr  <= video_address[ADDR_W-1:0];
      end
    end
  end

  // Stage 2: capture RAM data into whichever requester the tags name.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid_tag2   <= TAG_NONE;
      cpu_tag2   <= TAG_NONE;
      video_data <= '0;
      cpu_rdata  <= '0;
      miss_cnt   <= 16'd0;
    end else begin
      vid_tag2 <= vid_tag1;
      cpu_tag2 <= cpu_tag1;
      if (vid_tag1 == TAG_VID) begin
        video_data <= mem_rdata;
      end
      if (vid_tag1 == TAG_VID_DROP && miss_cnt != 16'hFFFF) begin
        miss_cnt <= miss_cnt + 16'd1;
      end
      if (cpu_tag1 == TAG_CPU_RD) begin
        cpu_rdata <= mem_rdata;
      end else if (cpu_tag1 == TAG_CPU_RD_OOR) begin
        cpu_rdata <= '0;
      end
    end
  end

  assign video_valid = (vid_tag2 != TAG_NONE);
  assign video_miss  = (vid_tag2 == TAG_VID_DROP);
  assign cpu_rvalid  = (cpu_tag2 != TAG_NONE);

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_vram_arbiter                                          |
// | Description : Directed self-checking bench for vram_arbiter with an    |
// |               asynchronous-read, synchronous-write RAM model.          |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_vram_arbiter;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pix_en;
  logic [31:0]       video_address;
  logic [DATA_W-1:0] video_data;
  logic              video_valid;
  logic              video_miss;
  logic [15:0]       miss_cnt;
  logic              cpu_req;
  logic              cpu_we;
  logic [31:0]       cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .video_address(video_address),
    .video_data(video_data), .video_valid(video_valid), .video_miss(video_miss),
    .miss_cnt(miss_cnt), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: data follows the address within the cycle, writes land on the edge.
  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_vdata"},  32'(video_data), 32'h0);
    check({tag, "_vvalid"}, 32'(video_valid), 32'h0);
    check({tag, "_vmiss"},  32'(video_miss), 32'h0);
    check({tag, "_misscnt"}, 32'(miss_cnt), 32'h0);
    check({tag, "_rdata"},  32'(cpu_rdata), 32'h0);
    check({tag, "_rvalid"}, 32'(cpu_rvalid), 32'h0);
    check({tag, "_maddr"},  32'(mem_addr), 32'h0);
    check({tag, "_mwe"},    32'(mem_we), 32'h0);
    check({tag, "_mwdata"}, 32'(mem_wdata), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; pix_en = 1'b0; video_address = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 4; i++) ram[32'h10000 + i] = 8'hA0 + 8'(i);
    ram[0] = 8'h77;

    // Reset state
    tick();
    tick();
    check_reset_outputs("reset");
    check("reset_gnt", 32'(cpu_gnt), 32'h0);
    rst_n = 1'b1;

    // Video streaming: four consecutive reads, returns in cycles 2..5
    for (int i = 0; i < 7; i++) begin
      tick();
      pix_en = (i < 4);
      video_address = 32'h10000 + i;
      #1;
      if (i >= 1 && i <= 4) check("vid_maddr", 32'(mem_addr), 32'h10000 + i - 1);
      check("vid_valid", 32'(video_valid), (i >= 2 && i <= 5) ? 32'h1 : 32'h0);
      if (i >= 2 && i <= 5) check("vid_data", 32'(video_data), 32'hA0 + i - 2);
      check("vid_miss", 32'(video_miss), 32'h0);
    end

    // Processor write then read-back
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h00123; cpu_wdata = 8'h5C;
    #1;
    check("wr_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    cpu_we = 1'b0;
    #1;
    check("rd_gnt", 32'(cpu_gnt), 32'h1);
    check("wr_mwe", 32'(mem_we), 32'h1);
    check("wr_maddr", 32'(mem_addr), 32'h123);
    check("wr_mwdata", 32'(mem_wdata), 32'h5C);
    tick();
    cpu_req = 1'b0;
    #1;
    check("idle_gnt", 32'(cpu_gnt), 32'h0);
    check("rd_mwe", 32'(mem_we), 32'h0);
    check("rd_rvalid_early", 32'(cpu_rvalid), 32'h0);
    tick();
    check("rd_rvalid", 32'(cpu_rvalid), 32'h1);
    check("rd_rdata", 32'(cpu_rdata), 32'h5C);
    tick();
    check("rd_rvalid_after", 32'(cpu_rvalid), 32'h0);

    // Starvation guard: four denials, forced grant on the fifth cycle
    for (int k = 0; k < 8; k++) begin
      tick();
      pix_en = (k <= 4);
      cpu_req = (k <= 4);
      cpu_we = 1'b0;
      cpu_addr = 32'h00123;
      video_address = (k < 4) ? 32'h10000 + k : 32'h10000;
      #1;
      check("starve_gnt", 32'(cpu_gnt), (k == 4) ? 32'h1 : 32'h0);
      check("starve_vvalid", 32'(video_valid), (k >= 2 && k <= 6) ? 32'h1 : 32'h0);
      check("starve_rvalid", 32'(cpu_rvalid), (k == 6) ? 32'h1 : 32'h0);
      if (k >= 2 && k <= 5) check("starve_vmiss_lo", 32'(video_miss), 32'h0);
      if (k == 5) check("starve_misscnt_pre", 32'(miss_cnt), 32'h0);
      if (k == 6) begin
        check("starve_vmiss", 32'(video_miss), 32'h1);
        check("starve_vdata_held", 32'(video_data), 32'hA3);
        check("starve_misscnt", 32'(miss_cnt), 32'h1);
        check("starve_rdata", 32'(cpu_rdata), 32'h5C);
      end
    end

    // Out-of-range processor read and write
    tick();
    pix_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0002_0000;
    #1;
    check("oor_rd_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    cpu_req = 1'b0;
    #1;
    check("oor_rd_maddr", 32'(mem_addr), 32'h0);
    tick();
    check("oor_rd_rvalid", 32'(cpu_rvalid), 32'h1);
    check("oor_rd_rdata", 32'(cpu_rdata), 32'h0);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_wdata = 8'h99;
    #1;
    check("oor_wr_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    cpu_req = 1'b0;
    #1;
    check("oor_wr_mwe", 32'(mem_we), 32'h0);
    tick();
    check("oor_wr_ram", 32'(ram[0]), 32'h77);

    // Interleaved video and out-of-range processor read after a write to A
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h00456; cpu_wdata = 8'h3E; pix_en = 1'b0;
    #1;
    check("mix_wr_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    pix_en = 1'b1; video_address = 32'h00456; cpu_we = 1'b0; cpu_addr = 32'h0002_0000;
    #1;
    check("mix_denied", 32'(cpu_gnt), 32'h0);
    check("mix_mwe", 32'(mem_we), 32'h1);
    tick();
    pix_en = 1'b0;
    #1;
    check("mix_rd_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    pix_en = 1'b1; cpu_req = 1'b0;
    #1;
    check("mix_v1_valid", 32'(video_valid), 32'h1);
    check("mix_v1_data", 32'(video_data), 32'h3E);
    check("mix_v1_rvalid", 32'(cpu_rvalid), 32'h0);
    tick();
    pix_en = 1'b0;
    #1;
    check("mix_c_rvalid", 32'(cpu_rvalid), 32'h1);
    check("mix_c_rdata", 32'(cpu_rdata), 32'h0);
    check("mix_c_vvalid", 32'(video_valid), 32'h0);
    tick();
    check("mix_v2_valid", 32'(video_valid), 32'h1);
    check("mix_v2_data", 32'(video_data), 32'h3E);
    check("mix_v2_rvalid", 32'(cpu_rvalid), 32'h0);
    check("mix_ram_a", 32'(ram[32'h456]), 32'h3E);

    // Reset one cycle after a read grant, with a video read also in flight
    tick();
    pix_en = 1'b1; video_address = 32'h10001;
    tick();
    pix_en = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h00123;
    #1;
    check("rst_rd_gnt", 32'(cpu_gnt), 32'h1);
    tick();
    cpu_req = 1'b0; rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_vvalid", 32'(video_valid), 32'h0);
      check("post_rst_rvalid", 32'(cpu_rvalid), 32'h0);
      check("post_rst_misscnt", 32'(miss_cnt), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
